// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED reset aggregation: FSM encoding,
// monitor channel indices and the index-width helper.
package vrased_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [15:0] RESET_HANDLER_DEFAULT = 16'h0000;

    localparam int X_STACK = 0;
    localparam int AC      = 1;
    localparam int ATOM    = 2;
    localparam int DMA_AC  = 3;
    localparam int DMA_DET = 4;
    localparam int DMA_XS  = 5;

    // Index width for n items, never below one bit.
    function automatic int fc_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/vrased_prio_enc.sv
// Lowest-index-first priority encoder; valid is high when any request is set.
module vrased_prio_enc
    import vrased_pkg::*;
#(
    parameter int N = 6,
    parameter int W = fc_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan upward and keep the first set bit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                idx   = W'(i);
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Merges the monitor violation lines into one registered MCU reset with
// minimum pulse width, optional hold-until-handler, cause capture and counter.
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter int          N_SRC           = 6,
    parameter logic [15:0] RESET_HANDLER   = RESET_HANDLER_DEFAULT,
    parameter int          PULSE_CYCLES    = 4,
    parameter int          HOLD_TO_HANDLER = 1,
    parameter int          CNT_W           = 8,
    localparam int         FC_W            = fc_width(N_SRC)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       pc,
    input  logic [N_SRC-1:0]  viol_in,
    input  logic [N_SRC-1:0]  viol_en,
    input  logic              clr_cause,
    output logic              reset,
    output logic              busy,
    output logic [N_SRC-1:0]  cause,
    output logic [FC_W-1:0]   first_cause,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam int            PC_W      = fc_width(PULSE_CYCLES);
    localparam logic [PC_W-1:0] PCNT_LOAD = PC_W'(PULSE_CYCLES - 1);

    logic [N_SRC-1:0] hit_s;
    logic             trig_s;
    logic [FC_W-1:0]  enc_idx_s;
    logic [1:0]       state_r,       state_nx_s;
    logic [PC_W-1:0]  pcnt_r,        pcnt_nx_s;
    logic [CNT_W-1:0] viol_cnt_r,    cnt_nx_s;
    logic [FC_W-1:0]  first_cause_r, fc_nx_s;
    logic [N_SRC-1:0] cause_r,       cause_nx_s;
    logic             reset_r;
    logic             busy_r;

    assign hit_s = viol_in & viol_en;

    vrased_prio_enc #(
        .N (N_SRC),
        .W (FC_W)
    ) u_prio_enc (
        .req   (hit_s),
        .idx   (enc_idx_s),
        .valid (trig_s)
    );

    // Next-state, pulse counter, counter and cause capture.
    always_comb begin
        state_nx_s = state_r;
        pcnt_nx_s  = pcnt_r;
        cnt_nx_s   = viol_cnt_r;
        fc_nx_s    = first_cause_r;
        cause_nx_s = cause_r | hit_s;
        case (state_r)
            ST_IDLE: begin
                // A same-cycle hit survives the clear.
                if (clr_cause) begin
                    cause_nx_s = hit_s;
                    fc_nx_s    = '0;
                end else begin
                    cause_nx_s = cause_r | hit_s;
                end
                if (trig_s) begin
                    state_nx_s = ST_PULSE;
                    pcnt_nx_s  = PCNT_LOAD;
                    cnt_nx_s   = (viol_cnt_r == {CNT_W{1'b1}}) ? viol_cnt_r
                                                               : viol_cnt_r + CNT_W'(1'b1);
                    fc_nx_s    = enc_idx_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (trig_s) begin
                    pcnt_nx_s = PCNT_LOAD;
                end else if (pcnt_r == '0) begin
                    state_nx_s = (HOLD_TO_HANDLER != 0) ? ST_HOLD : ST_IDLE;
                end else begin
                    pcnt_nx_s = pcnt_r - PC_W'(1'b1);
                end
            end
            ST_HOLD: begin
                // A fresh violation outranks reaching the handler.
                if (trig_s) begin
                    state_nx_s = ST_PULSE;
                    pcnt_nx_s  = PCNT_LOAD;
                end else if (pc == RESET_HANDLER) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pcnt_nx_s  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pcnt_r        <= '0;
            viol_cnt_r    <= '0;
            first_cause_r <= '0;
            cause_r       <= '0;
            reset_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            pcnt_r        <= pcnt_nx_s;
            viol_cnt_r    <= cnt_nx_s;
            first_cause_r <= fc_nx_s;
            cause_r       <= cause_nx_s;
            reset_r       <= (state_nx_s != ST_IDLE);
            busy_r        <= (state_nx_s != ST_IDLE);
        end
    end

    assign reset       = reset_r;
    assign busy        = busy_r;
    assign cause       = cause_r;
    assign first_cause = first_cause_r;
    assign viol_cnt    = viol_cnt_r;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for three configurations of vrased_reset_ctrl sharing one stimulus.
module tb_vrased_reset_ctrl;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic [5:0] cause;
        logic [2:0] fc;
        logic [7:0] cnt;
    } obs_t;

    localparam int P_PULSE [3] = '{4, 3, 4};
    localparam int P_HOLD  [3] = '{1, 0, 1};
    localparam int P_CMAX  [3] = '{255, 255, 3};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic [5:0]  viol_in;
    logic [5:0]  viol_en;
    logic        clr_cause;

    logic       a_reset, a_busy, b_reset, b_busy, c_reset, c_busy;
    logic [5:0] a_cause, b_cause, c_cause;
    logic [2:0] a_fc, b_fc, c_fc;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   high_cnt [3];
    int   m_st [3];
    int   m_pcnt [3];
    int   m_cnt [3];
    int   m_fc [3];
    logic [5:0] m_cause [3];
    obs_t sb_q [$];

    always #5 clk = ~clk;

    vrased_reset_ctrl u_a (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol_in(viol_in), .viol_en(viol_en),
        .clr_cause(clr_cause), .reset(a_reset), .busy(a_busy), .cause(a_cause),
        .first_cause(a_fc), .viol_cnt(a_cnt)
    );

    vrased_reset_ctrl #(.PULSE_CYCLES(3), .HOLD_TO_HANDLER(0)) u_b (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol_in(viol_in), .viol_en(viol_en),
        .clr_cause(clr_cause), .reset(b_reset), .busy(b_busy), .cause(b_cause),
        .first_cause(b_fc), .viol_cnt(b_cnt)
    );

    vrased_reset_ctrl #(.CNT_W(2)) u_c (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol_in(viol_in), .viol_en(viol_en),
        .clr_cause(clr_cause), .reset(c_reset), .busy(c_busy), .cause(c_cause),
        .first_cause(c_fc), .viol_cnt(c_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input int i);
        case (i)
            0:       get_obs = '{a_reset, a_busy, a_cause, a_fc, a_cnt};
            1:       get_obs = '{b_reset, b_busy, b_cause, b_fc, b_cnt};
            2:       get_obs = '{c_reset, c_busy, c_cause, c_fc, {6'b0, c_cnt}};
            default: get_obs = '0;
        endcase
    endfunction

    task automatic check_obs(input int i, input string tag, input obs_t e);
        obs_t o;
        o = get_obs(i);
        check_val($sformatf("%s[%0d].reset", tag, i), 32'(o.rst),   32'(e.rst));
        check_val($sformatf("%s[%0d].busy",  tag, i), 32'(o.busy),  32'(e.busy));
        check_val($sformatf("%s[%0d].cause", tag, i), 32'(o.cause), 32'(e.cause));
        check_val($sformatf("%s[%0d].fc",    tag, i), 32'(o.fc),    32'(e.fc));
        check_val($sformatf("%s[%0d].cnt",   tag, i), 32'(o.cnt),   32'(e.cnt));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_pcnt[i] = 0; m_cnt[i] = 0; m_fc[i] = 0; m_cause[i] = 6'b0;
        end
    endtask

    task automatic model_step(input int i);
        logic [5:0] hit;
        int low;
        hit = viol_in & viol_en;
        low = 0;
        for (int k = 5; k >= 0; k--) if (hit[k]) low = k;
        if (!reset_n) begin
            m_st[i] = 0; m_pcnt[i] = 0; m_cnt[i] = 0; m_fc[i] = 0; m_cause[i] = 6'b0;
        end else if (m_st[i] == 0) begin
            if (clr_cause) begin
                m_cause[i] = hit;
                m_fc[i] = 0;
            end else begin
                m_cause[i] = m_cause[i] | hit;
            end
            if (hit != 6'b0) begin
                m_st[i] = 1;
                m_pcnt[i] = P_PULSE[i] - 1;
                if (m_cnt[i] < P_CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
                m_fc[i] = low;
            end
        end else if (m_st[i] == 1) begin
            m_cause[i] = m_cause[i] | hit;
            if (hit != 6'b0) m_pcnt[i] = P_PULSE[i] - 1;
            else if (m_pcnt[i] == 0) m_st[i] = (P_HOLD[i] != 0) ? 2 : 0;
            else m_pcnt[i] = m_pcnt[i] - 1;
        end else begin
            m_cause[i] = m_cause[i] | hit;
            if (hit != 6'b0) begin
                m_st[i] = 1;
                m_pcnt[i] = P_PULSE[i] - 1;
            end else if (pc == 16'h0000) begin
                m_st[i] = 0;
            end
        end
    endtask

    // One clock: model advances at the edge, DUT compared at the falling edge.
    task automatic tick();
        obs_t e;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            e.rst   = (m_st[i] != 0);
            e.busy  = (m_st[i] != 0);
            e.cause = m_cause[i];
            e.fc    = 3'(m_fc[i]);
            e.cnt   = 8'(m_cnt[i]);
            sb_q.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = sb_q.pop_front();
            check_obs(i, "sb", e);
            if (get_obs(i).rst) high_cnt[i]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic release_hold();
        pc = 16'h0000;
        tick();
        pc = 16'h1234;
    endtask

    task automatic clear_cause_tick();
        clr_cause = 1'b1;
        tick();
        clr_cause = 1'b0;
    endtask

    task automatic zero_high();
        for (int i = 0; i < 3; i++) high_cnt[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; pc = 16'h1234; viol_in = 6'b0; viol_en = 6'h3F; clr_cause = 1'b0;
        model_clear();
        zero_high();
        #1;
        for (int i = 0; i < 3; i++) check_obs(i, "por", '0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(2);

        // Single violation on bit 2 with hold mode
        viol_in = 6'b000100; tick(); viol_in = 6'b0;
        check_val("t1_reset", 32'(a_reset), 32'd1);
        check_val("t1_fc",    32'(a_fc),    32'd2);
        check_val("t1_cause", 32'(a_cause), 32'h04);
        check_val("t1_cnt",   32'(a_cnt),   32'd1);
        ticks(8);
        check_val("t1_a_high", 32'(high_cnt[0]), 32'd9);
        check_val("t1_b_high", 32'(high_cnt[1]), 32'd3);
        release_hold();
        check_val("t1_release", 32'(a_reset), 32'd0);

        // Two-source violation on the short, no-hold instance
        clear_cause_tick();
        zero_high();
        viol_in = 6'b110000; tick(); viol_in = 6'b0;
        check_val("t2_fc",    32'(b_fc),    32'd4);
        check_val("t2_cause", 32'(b_cause), 32'h30);
        ticks(5);
        check_val("t2_b_high", 32'(high_cnt[1]), 32'd3);
        release_hold();

        // Disabled source is ignored
        clear_cause_tick();
        viol_en = 6'b111110;
        viol_in = 6'b000001; ticks(2);
        check_val("t3_noreset", 32'(a_reset), 32'd0);
        check_val("t3_nocause", 32'(a_cause), 32'd0);
        check_val("t3_nocnt",   32'(a_cnt),   32'd2);
        viol_in = 6'b000011; tick(); viol_in = 6'b0;
        check_val("t3_fc",    32'(a_fc),    32'd1);
        check_val("t3_cause", 32'(a_cause), 32'h02);
        ticks(4);
        release_hold();

        // Retrigger during the pulse
        viol_en = 6'h3F;
        clear_cause_tick();
        zero_high();
        viol_in = 6'b000001; tick(); viol_in = 6'b0;
        ticks(2);
        viol_in = 6'b001000; tick(); viol_in = 6'b0;
        ticks(6);
        check_val("t4_b_high", 32'(high_cnt[1]), 32'd6);
        check_val("t4_cnt",    32'(a_cnt),   32'd4);
        check_val("t4_cause",  32'(a_cause), 32'h09);
        check_val("t4_fc",     32'(a_fc),    32'd0);
        release_hold();

        // Counter saturation on the 2-bit instance
        for (int k = 0; k < 7; k++) begin
            viol_in = 6'b000001; tick(); viol_in = 6'b0;
            ticks(4);
            release_hold();
            if (k == 2) check_val("t5_sat3", 32'(c_cnt), 32'd3);
        end
        check_val("t5_csat", 32'(c_cnt), 32'd3);
        check_val("t5_acnt", 32'(a_cnt), 32'd11);
        viol_in = 6'b100000;
        clear_cause_tick();
        viol_in = 6'b0;
        check_val("t5_clr_set", 32'(a_cause), 32'h20);
        ticks(4);
        release_hold();

        // Async reset during HOLD
        viol_in = 6'b000001; tick(); viol_in = 6'b0;
        ticks(5);
        clear_cause_tick();
        check_val("t6_clr_ignored", 32'(a_cause), 32'h21);
        check_val("t6_busy", 32'(a_busy), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_obs(i, "arst", '0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        viol_in = 6'b000100; tick(); viol_in = 6'b0;
        check_val("t6_fc",    32'(a_fc),    32'd2);
        check_val("t6_cause", 32'(a_cause), 32'h04);
        check_val("t6_cnt",   32'(a_cnt),   32'd1);
        ticks(4);
        check_val("t6_hold", 32'(a_reset), 32'd1);
        release_hold();
        check_val("t6_release", 32'(a_reset), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
